// File: rtl/router_fsm_multi.sv
// rtl/router_fsm_multi.sv - parametrised router control FSM with out-of-range drop path
// Latches the destination at header time and qualifies FIFO status and soft resets against it.
module router_fsm_multi #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [ADDR_W-1:0]     data_in,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic                  fifo_full,
    input  logic [NUM_PORTS-1:0]  soft_reset,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic [NUM_PORTS-1:0]  dest_sel,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  full_state,
    output logic                  laf_state,
    output logic                  rst_int_reg,
    output logic                  write_enb_reg,
    output logic                  busy,
    output logic                  drop_state,
    output logic [DROP_CNT_W-1:0] drop_count
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        WAIT_TILL_EMPTY    = 4'd1,
        LOAD_FIRST_DATA    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8,
        DROP_PARITY        = 4'd9
    } state_t;

    localparam logic [ADDR_W:0]     PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] PORT0     = NUM_PORTS'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    state_t               state;
    logic [NUM_PORTS-1:0] hdr_onehot;
    logic                 addr_in_range;
    logic                 hdr_empty;
    logic                 sel_empty;
    logic                 sr;

    assign hdr_onehot    = PORT0 << data_in;
    assign addr_in_range = {1'b0, data_in} < PORT_LIMIT;
    assign hdr_empty     = |(fifo_empty & hdr_onehot);
    // dest_sel is one-hot (or zero), so masking picks out only the latched port's flags
    assign sel_empty     = |(fifo_empty & dest_sel);
    assign sr            = |(soft_reset & dest_sel);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= DECODE_ADDRESS;
            dest_sel   <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        if (addr_in_range) begin
                            dest_sel <= hdr_onehot;
                            state    <= hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        end else begin
                            dest_sel <= '0;
                            state    <= DROP_PACKET;
                        end
                    end
                end
                DROP_PACKET: begin
                    if (!pkt_valid) state <= DROP_PARITY;
                end
                DROP_PARITY: begin
                    state <= DECODE_ADDRESS;
                    if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
                end
                default: begin
                    if (sr) begin
                        state    <= DECODE_ADDRESS;
                        dest_sel <= '0;
                    end else begin
                        case (state)
                            WAIT_TILL_EMPTY:    if (sel_empty) state <= LOAD_FIRST_DATA;
                            LOAD_FIRST_DATA:    state <= LOAD_DATA;
                            LOAD_DATA: begin
                                if (fifo_full)       state <= FIFO_FULL_STATE;
                                else if (!pkt_valid) state <= LOAD_PARITY;
                            end
                            FIFO_FULL_STATE:    if (!fifo_full) state <= LOAD_AFTER_FULL;
                            LOAD_AFTER_FULL: begin
                                if (parity_done)        state <= DECODE_ADDRESS;
                                else if (low_pkt_valid) state <= LOAD_PARITY;
                                else                    state <= LOAD_DATA;
                            end
                            LOAD_PARITY:        state <= CHECK_PARITY_ERROR;
                            CHECK_PARITY_ERROR: state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                            default:            state <= DECODE_ADDRESS;
                        endcase
                    end
                end
            endcase
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY);
    assign drop_state    = (state == DROP_PACKET) || (state == DROP_PARITY);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA) ||
                             (state == DROP_PACKET) || (state == DROP_PARITY));

endmodule

// File: doc/router_fsm_multi.md
Name: router_fsm_multi

Overview:
- Parametrised successor of the router control FSM. Sequences packet loading from the input register into one of NUM_PORTS destination FIFOs.
- Generalises the hard-wired 3-port address decode to NUM_PORTS ports. Latches the destination at header time and qualifies FIFO status and soft resets against that latched port only.
- Adds a drop path for out-of-range addresses and a saturating dropped-packet counter.
- Sits between the input register/parity block and the FIFO bank and synchroniser.

Parameters:
NUM_PORTS, 3, number of destination FIFOs (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS
DROP_CNT_W, 8, width of dropped-packet counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pkt_valid  input  1  source packet valid
data_in  input  ADDR_W  header address bits (data[ADDR_W-1:0]), sampled in DECODE_ADDRESS
fifo_empty  input  NUM_PORTS  per-FIFO empty flags
fifo_full  input  1  full flag of currently selected FIFO (from synchroniser)
soft_reset  input  NUM_PORTS  per-FIFO soft reset from synchroniser timeout
parity_done  input  1  parity byte written
low_pkt_valid  input  1  pkt_valid fell while FIFO full
dest_sel  output  NUM_PORTS  one-hot latched destination, all-zero when none
detect_add  output  1  state==DECODE_ADDRESS
lfd_state  output  1  state==LOAD_FIRST_DATA
ld_state  output  1  state==LOAD_DATA
full_state  output  1  state==FIFO_FULL_STATE
laf_state  output  1  state==LOAD_AFTER_FULL
rst_int_reg  output  1  state==CHECK_PARITY_ERROR
write_enb_reg  output  1  state in {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY}
busy  output  1  stall to source
drop_state  output  1  state in {DROP_PACKET, DROP_PARITY}
drop_count  output  DROP_CNT_W  saturating count of dropped packets

Behaviour:
Reset and encoding:
- Reset is asynchronous and active-high. reset=1 forces state=DECODE_ADDRESS, dest_sel=0 and drop_count=0.
- After reset: detect_add=1, all other state flags 0, busy=0.
- 4-bit state encoding. Unused encodings return to DECODE_ADDRESS on the next clock.
- All state-flag outputs are Moore decodes of the state register, with zero additional latency.
- busy=0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET and DROP_PARITY; busy=1 in every other state.

Definitions:
- "sr" = soft_reset[latched port]. Bits of soft_reset for other ports are ignored.
- sr has highest priority in every state except DECODE_ADDRESS and DROP_*; when set, the next state is DECODE_ADDRESS.

Transitions:
- DECODE_ADDRESS, pkt_valid=0: stay.
- DECODE_ADDRESS, pkt_valid=1 and data_in<NUM_PORTS: latch dest_sel=onehot(data_in). Go to LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY.
- DECODE_ADDRESS, pkt_valid=1 and data_in>=NUM_PORTS: go to DROP_PACKET; dest_sel=0.
- WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when the latched port's fifo_empty=1. The latched port is used; data_in is not re-sampled.
- LOAD_FIRST_DATA: go to LOAD_DATA.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- DROP_PACKET: stay while pkt_valid=1; on pkt_valid=0 go to DROP_PARITY. This consumes the trailing parity byte.
- DROP_PARITY: go to DECODE_ADDRESS.

dest_sel and drop_count:
- dest_sel holds its value from the latch until the next DECODE_ADDRESS exit with pkt_valid=1.
- dest_sel clears to 0 when a soft-reset abort returns the FSM to DECODE_ADDRESS.
- drop_count increments on the DROP_PARITY->DECODE_ADDRESS transition and saturates at all-ones (no wrap).

Simultaneous events:
- sr together with fifo_full or pkt_valid: sr wins.
- parity_done together with low_pkt_valid in LOAD_AFTER_FULL: parity_done wins.

Test Plan:
- NUM_PORTS=3, all fifo_empty=1, header data_in=1, pkt_valid high 4 cycles -> states DA,LFD,LD×3,LP,CPE,DA; dest_sel=3'b010; write_enb_reg high 4 cycles; busy low only in DA/LD.
- fifo_empty[2]=0, header data_in=2 -> WAIT_TILL_EMPTY with busy=1. Toggle data_in to 0 while waiting -> FSM stays. Set fifo_empty[2]=1 -> LFD next cycle.
- In LD, assert fifo_full 3 cycles then deassert with low_pkt_valid=1 -> FULL×3, LAF, LP, CPE, DA; full_state high exactly 3 cycles.
- Header data_in=3 with NUM_PORTS=3, pkt_valid high 5 cycles -> DROP_PACKET×5, DROP_PARITY, DA; write_enb_reg never high; drop_count 0->1. Force drop_count to 255 -> remains 255.
- Packet to port 0 in LD. Pulse soft_reset[1] -> no effect. Pulse soft_reset[0] -> DA next cycle, dest_sel=0.
- Assert reset asynchronously mid-FIFO_FULL_STATE, between clock edges -> detect_add=1, dest_sel=0, drop_count=0 immediately.
